loadable_computer: RTL and testbench
====================================

# loadable_computer

Parametrised successor to the fixed-ROM Hack computer top level. Instantiates the existing `cpu` and `memory` units and adds a writable instruction ROM of configurable depth. Adds a streaming program-load port and a run-control state machine (load / idle / run / halt). A run ends automatically when the CPU fetches past the end of the loaded program. Used as the top-level core for FPGA builds where programs arrive over a host link instead of being baked into the bitstream.

## Interface
Parameters:
- `ROM_ADDR_WIDTH`, 12: instruction ROM address width; depth = 2^ROM_ADDR_WIDTH words of 16 bits.

Ports:
- `clk` in 1: single clock. The ROM is read on the falling edge; all other state changes on the rising edge.
- `reset` in 1: synchronous, active-high. Clock and reset are `clk` and `reset`; reset is synchronous and active-high.
- `prog_data` in 16: instruction word being loaded.
- `prog_valid` in 1: `prog_data` is valid.
- `prog_last` in 1: the current word is the final word of the program.
- `prog_ready` out 1: high only in LOAD.
- `start` in 1: begin execution from PC 0. Effective in IDLE and HALT.
- `stop` in 1: abort a run. Effective in RUN.
- `load_req` in 1: return to LOAD. Effective in IDLE and HALT.
- `state` out 2: LOAD=0, IDLE=1, RUN=2, HALT=3.
- `prog_len` out ROM_ADDR_WIDTH+1: number of words loaded.
- `pc` out 16: the CPU's `nextPC`.
- `instr_count` out 32: instructions retired (see Configuration).

## Operation
- **Reset:** state=LOAD, load_addr=0, prog_len=0, instr_count=0, prog_ready=1. ROM contents are not cleared; data RAM is untouched.
- **LOAD:**
  - A word is accepted on a rising edge when `prog_valid & prog_ready`. It is written to `rom[load_addr]`, load_addr increments, and prog_len = load_addr+1.
  - If the accepted word has `prog_last`, or load_addr == depth-1, the next state is IDLE and load_addr clears to 0.
  - `start`, `stop` and `load_req` are ignored in LOAD.
- **IDLE:**
  - `load_req` → LOAD, with prog_len=0.
  - Otherwise `start` → RUN, with instr_count cleared.
  - `load_req` has priority over `start`.
- **RUN:**
  - The CPU runs, one instruction per rising edge.
  - `oob` = (`nextPC` ≥ prog_len). The comparison is 16-bit unsigned, with prog_len zero-extended.
  - `stop` or `oob` → HALT. If both occur in the same cycle, the result is still HALT.
- **HALT:**
  - `load_req` → LOAD.
  - Otherwise `start` → RUN, restarting from PC 0 with instr_count cleared.
- **CPU reset:** `cpu_reset = reset | (state != RUN) | oob`. This is combinational, so the out-of-range instruction is never executed.
- **Memory write enable:** `memory.load = writeM & ~cpu_reset`. No RAM write occurs on a halting edge or outside RUN.
- **ROM read:**
  - On each falling edge, `instruction <= rom[nextPC[ROM_ADDR_WIDTH-1:0]]`.
  - Higher PC bits are ignored for indexing; `oob` still uses all 16 bits.
- **Instruction count:** on each rising edge in RUN with `cpu_reset` low, instr_count increments, saturating at 2^32-1.

## Timing
- One instruction executes per cycle in RUN; there is no fetch stall.
- Half-cycle ROM latency: the word for address `nextPC` is presented to the CPU at the next rising edge.
- First instruction executed:
  - Edge E: `start` sampled in IDLE.
  - Falling edge after E: `rom[0]` fetched (the CPU was in reset, so `nextPC`=0).
  - Edge E+1: `rom[0]` executes.
- `prog_ready` deasserts on the edge that accepts the final word.
- `state` is registered and changes one edge after the triggering input or condition.
- `reset` mid-run: the CPU is reset and the state machine goes to LOAD. ROM contents are retained but unreachable until reloaded, because prog_len=0.
- Depth-overflow load: the word at depth-1 is accepted and the state machine goes to IDLE. Subsequent `prog_valid` is ignored (`prog_ready`=0).

## Configuration
- `INSTR_COUNT_EN` defined: the 32-bit saturating counter is present and drives `instr_count`.
- `INSTR_COUNT_EN` undefined: `instr_count` is tied to 0 and no counter logic is synthesised.

## Test plan
- **Reset:** assert `reset` for 2 cycles → state=0, prog_ready=1, prog_len=0, instr_count=0.
- **Load and run:**
  - Stimulus: load 4 words `@2`, `D=A`, `@0`, `M=D` (0x0002, 0xEC10, 0x0000, 0xE308) with `prog_last` on the 4th, then `start`.
  - Required response:
    - state=IDLE after the 4th word, prog_len=4.
    - RAM[0]=2.
    - HALT on the edge where pc=4.
    - instr_count=4.
- **Stop:** load `@0`, `0;JMP` (0x0000, 0xEA87), `start`, wait 50 cycles, pulse `stop` → state=HALT within 1 edge, instr_count=50±1, no RAM writes.
- **Depth overflow:** with ROM_ADDR_WIDTH=3, stream 10 words without `prog_last` → 8 words accepted, prog_len=8, state=IDLE, prog_ready=0 for words 9 and 10.
- **Priority:** in HALT, assert `start` and `load_req` in the same cycle → state=LOAD, prog_len=0.
- **Mid-run reset:** pulse `reset` during RUN → state=LOAD next edge. Reloading a 1-word program and running it gives instr_count=1, then HALT.

Source files
------------

// File: rtl/loadable_computer.sv
// Hack computer top level with a streamed, writable instruction ROM and load/idle/run/halt control.
// Define INSTR_COUNT_EN to build the saturating retired-instruction counter behind instr_count.

module cpu (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_m,
    input  logic [15:0] instruction,
    output logic [15:0] out_m,
    output logic        write_m,
    output logic [14:0] address_m,
    output logic [15:0] next_pc
);
    logic [15:0] a_reg, d_reg, pc_reg;
    logic [15:0] x0, x1, y0, y1, f_out, alu_out;
    logic        is_c, zr, ng, jump;

    // Only a 111 prefix decodes as a C-instruction; other 1xx words retire as no-ops.
    always_comb begin
        is_c    = &instruction[15:13];
        x0      = instruction[11] ? 16'h0000 : d_reg;
        x1      = instruction[10] ? ~x0 : x0;
        y0      = instruction[9] ? 16'h0000 : (instruction[12] ? in_m : a_reg);
        y1      = instruction[8] ? ~y0 : y0;
        f_out   = instruction[7] ? (x1 + y1) : (x1 & y1);
        alu_out = instruction[6] ? ~f_out : f_out;
        zr      = (alu_out == 16'h0000);
        ng      = alu_out[15];
        jump    = is_c & ((instruction[2] & ng) | (instruction[1] & zr) |
                          (instruction[0] & ~ng & ~zr));
    end

    assign out_m     = alu_out;
    assign write_m   = is_c & instruction[3];
    assign address_m = a_reg[14:0];
    assign next_pc   = pc_reg;

    // A and D are gated by reset too, so an instruction held off by reset has no effect at all.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= jump ? a_reg : pc_reg + 16'd1;
            if (!instruction[15])
                a_reg <= instruction;
            else if (is_c && instruction[5])
                a_reg <= alu_out;
            if (is_c && instruction[4])
                d_reg <= alu_out;
        end
    end
endmodule

module memory (
    input  logic        clk,
    input  logic        load,
    input  logic [14:0] address,
    input  logic [15:0] wdata,
    output logic [15:0] rdata
);
    logic [15:0] ram [32768];

    always_ff @(posedge clk) begin
        if (load)
            ram[address] <= wdata;
    end

    assign rdata = ram[address];
endmodule

module loadable_computer #(
    parameter int ROM_ADDR_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [15:0]             prog_data,
    input  logic                    prog_valid,
    input  logic                    prog_last,
    output logic                    prog_ready,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    load_req,
    output logic [1:0]              state,
    output logic [ROM_ADDR_WIDTH:0] prog_len,
    output logic [15:0]             pc,
    output logic [31:0]             instr_count
);
    localparam int DEPTH = 1 << ROM_ADDR_WIDTH;

    typedef enum logic [1:0] {LOAD = 2'd0, IDLE = 2'd1, RUN = 2'd2, HALT = 2'd3} state_t;

    state_t                    state_q, state_d;
    logic [ROM_ADDR_WIDTH-1:0] load_addr;
    logic [ROM_ADDR_WIDTH:0]   len_q;
    logic [15:0]               rom [DEPTH];
    logic [15:0]               instruction, next_pc, in_m, out_m;
    logic [14:0]               address_m;
    logic                      write_m, oob, cpu_reset, mem_load;
    logic                      accept, load_done, clear_len, begin_run;

    // Load port: a word transfers on a rising edge when prog_valid && prog_ready (ready only in LOAD).
    assign prog_ready = (state_q == LOAD);
    assign oob        = (next_pc >= 16'(len_q));
    assign cpu_reset  = reset | (state_q != RUN) | oob;
    assign mem_load   = write_m & ~cpu_reset;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        load_done = 1'b0;
        clear_len = 1'b0;
        begin_run = 1'b0;
        case (state_q)
            LOAD: begin
                if (prog_valid) begin
                    accept = 1'b1;
                    if (prog_last || load_addr == '1) begin
                        load_done = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            IDLE, HALT: begin
                if (load_req) begin
                    clear_len = 1'b1;
                    state_d   = LOAD;
                end else if (start) begin
                    begin_run = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (stop || oob)
                    state_d = HALT;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= LOAD;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_addr <= '0;
            len_q     <= '0;
        end else if (clear_len) begin
            load_addr <= '0;
            len_q     <= '0;
        end else if (accept) begin
            load_addr <= load_done ? '0 : load_addr + 1'b1;
            len_q     <= {1'b0, load_addr} + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !reset)
            rom[load_addr] <= prog_data;
    end

    // Falling-edge fetch gives the CPU the word at next_pc by the following rising edge.
    always_ff @(negedge clk) begin
        instruction <= rom[next_pc[ROM_ADDR_WIDTH-1:0]];
    end

`ifdef INSTR_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || begin_run)
            count_q <= '0;
        else if (!cpu_reset && count_q != '1)
            count_q <= count_q + 32'd1;
    end

    assign instr_count = count_q;
`else
    assign instr_count = '0;
`endif

    assign state    = state_q;
    assign prog_len = len_q;
    assign pc       = next_pc;

    cpu u_cpu (
        .clk         (clk),
        .reset       (cpu_reset),
        .in_m        (in_m),
        .instruction (instruction),
        .out_m       (out_m),
        .write_m     (write_m),
        .address_m   (address_m),
        .next_pc     (next_pc)
    );

    memory u_memory (
        .clk     (clk),
        .load    (mem_load),
        .address (address_m),
        .wdata   (out_m),
        .rdata   (in_m)
    );
endmodule

// File: tb/tb_loadable_computer.sv
// Directed bench for loadable_computer built with an 8-word ROM so the depth limit is reachable.
module tb_loadable_computer;
    localparam int AW = 3;
`ifdef INSTR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] prog_data;
    logic        prog_valid, prog_last, prog_ready;
    logic        start, stop, load_req;
    logic [1:0]  state;
    logic [AW:0] prog_len;
    logic [15:0] pc;
    logic [31:0] instr_count;

    int checks = 0;
    int failures = 0;
    int write_count = 0;
    int wb;

    loadable_computer #(.ROM_ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_data   (prog_data),
        .prog_valid  (prog_valid),
        .prog_last   (prog_last),
        .prog_ready  (prog_ready),
        .start       (start),
        .stop        (stop),
        .load_req    (load_req),
        .state       (state),
        .prog_len    (prog_len),
        .pc          (pc),
        .instr_count (instr_count)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // RAM write monitor: sampled late in the low phase, when the write enable is settled.
    always @(negedge clk) begin
        #3;
        if (dut.mem_load)
            write_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [15:0] data, input logic last);
        prog_data  = data;
        prog_valid = 1'b1;
        prog_last  = last;
        tick();
        prog_valid = 1'b0;
        prog_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; prog_data = '0; prog_valid = 1'b0; prog_last = 1'b0;
        start = 1'b0; stop = 1'b0; load_req = 1'b0;

        // reset
        tick(2);
        check("reset_state", 32'(state), 32'd0);
        check("reset_ready", 32'(prog_ready), 32'd1);
        check("reset_len", 32'(prog_len), 32'd0);
        check("reset_count", instr_count, 32'd0);
        reset = 1'b0;
        pulse_start();
        check("load_ignores_start", 32'(state), 32'd0);

        // load and run: @2, D=A, @0, M=D
        send_word(16'h0002, 1'b0);
        send_word(16'hEC10, 1'b0);
        send_word(16'h0000, 1'b0);
        check("ready_before_last", 32'(prog_ready), 32'd1);
        send_word(16'hE308, 1'b1);
        check("load_idle", 32'(state), 32'd1);
        check("load_len", 32'(prog_len), 32'd4);
        check("load_ready_low", 32'(prog_ready), 32'd0);
        wb = write_count;
        pulse_start();
        check("run_state", 32'(state), 32'd2);
        check("run_pc0", 32'(pc), 32'd0);
        tick(4);
        check("run_pc_end", 32'(pc), 32'd4);
        check("run_still_run", 32'(state), 32'd2);
        tick();
        check("run_halt", 32'(state), 32'd3);
        check("run_ram0", 32'(dut.u_memory.ram[0]), 32'd2);
        check("run_count", instr_count, cnt(4));
        check("run_writes", 32'(write_count - wb), 32'd1);
        check("halt_pc", 32'(pc), 32'd0);

        // stop: @0, 0;JMP
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        check("reload_state", 32'(state), 32'd0);
        check("reload_len", 32'(prog_len), 32'd0);
        send_word(16'h0000, 1'b0);
        send_word(16'hEA87, 1'b1);
        check("stop_len", 32'(prog_len), 32'd2);
        wb = write_count;
        pulse_start();
        tick(50);
        check("stop_running", 32'(state), 32'd2);
        check("stop_count50", instr_count, cnt(50));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_halt", 32'(state), 32'd3);
        check("stop_count51", instr_count, cnt(51));
        tick();
        check("halt_count_hold", instr_count, cnt(51));
        check("stop_no_writes", 32'(write_count - wb), 32'd0);

        // priority: load_req beats start in HALT
        start = 1'b1;
        load_req = 1'b1;
        tick();
        start = 1'b0;
        load_req = 1'b0;
        check("prio_state", 32'(state), 32'd0);
        check("prio_len", 32'(prog_len), 32'd0);
        check("prio_ready", 32'(prog_ready), 32'd1);

        // depth overflow: 10 words, no prog_last
        for (int i = 0; i < 10; i++) begin
            check("depth_ready", 32'(prog_ready), (i < 8) ? 32'd1 : 32'd0);
            prog_data  = 16'h0010 + 16'(i);
            prog_valid = 1'b1;
            tick();
        end
        prog_valid = 1'b0;
        check("depth_idle", 32'(state), 32'd1);
        check("depth_len", 32'(prog_len), 32'd8);
        check("depth_rom0_kept", 32'(dut.rom[0]), 32'h0010);
        pulse_start();
        tick(8);
        check("depth_pc8", 32'(pc), 32'd8);
        check("depth_run", 32'(state), 32'd2);
        tick();
        check("depth_halt", 32'(state), 32'd3);
        check("depth_count", instr_count, cnt(8));

        // mid-run reset, then a 1-word program
        pulse_start();
        tick(3);
        check("midrun_running", 32'(state), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrun_state", 32'(state), 32'd0);
        check("midrun_len", 32'(prog_len), 32'd0);
        check("midrun_count", instr_count, 32'd0);
        check("midrun_pc", 32'(pc), 32'd0);
        send_word(16'h0005, 1'b1);
        check("one_idle", 32'(state), 32'd1);
        check("one_len", 32'(prog_len), 32'd1);
        pulse_start();
        tick();
        check("one_count", instr_count, cnt(1));
        check("one_pc", 32'(pc), 32'd1);
        tick();
        check("one_halt", 32'(state), 32'd3);
        check("one_count_final", instr_count, cnt(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
